call_return_responder: RTL
==========================

Name: call_return_responder

Overview:
- Callee side of the simulator's call/return handshake.
- Accepts one call request carrying two operands and an opcode, then computes either a sum (single step) or a product (sequential shift-add over WIDTH cycles).
- Returns the result through a valid/ready return channel and holds it until the initiator consumes it.
- Serves as the hardware counterpart to a task/function invocation: the initiator issues the call, this block responds.

Parameters:
- WIDTH, 8, operand width in bits; result width is 2*WIDTH.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- call_valid  input  1  initiator presents a call.
- call_ready  output  1  responder can accept a call.
- call_op  input  1  0 = add, 1 = multiply.
- call_a  input  WIDTH  first operand (unsigned).
- call_b  input  WIDTH  second operand (unsigned).
- ret_valid  output  1  result available.
- ret_ready  input  1  initiator accepts result.
- ret_data  output  2*WIDTH  result.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (rst_n low, asynchronous): state = IDLE, call_ready = 1, ret_valid = 0, ret_data = 0, busy = 0, internal accumulator/multiplier/counter = 0.
- Accept: call accepted on an edge where call_valid && call_ready. Operands and op are latched on that edge; later changes on the call_* inputs are ignored.
- States:
  - IDLE: call_ready = 1.
    - On accept with op = 0, go to RET with ret_data = zero-extended call_a + call_b (carry lands in bit WIDTH, upper bits 0).
    - On accept with op = 1, go to MUL with acc = 0, mcand = {WIDTH zeros, call_a}, mplier = call_b, cnt = 0.
  - MUL: call_ready = 0. Each cycle:
    - if mplier[0], acc += mcand;
    - mcand <<= 1; mplier >>= 1; cnt++.
    - When cnt reaches WIDTH-1 in this cycle, go to RET with ret_data = final acc.
    - Exactly WIDTH cycles are spent in MUL; no early exit on zero multiplier.
  - RET: ret_valid = 1; ret_data is stable. On ret_valid && ret_ready, go to IDLE and ret_valid drops on that edge. Otherwise hold indefinitely.
- Latency from accept edge to ret_valid high:
  - add: 1 edge (ret_valid visible in the cycle after accept);
  - multiply: WIDTH+1 edges.
- Arithmetic:
  - Both operands are unsigned.
  - The product is exact in 2*WIDTH bits and never overflows.
  - The sum is exact in WIDTH+1 bits.
- No pipelining: one call outstanding at a time. call_ready is low from the accept edge until the return-handshake edge.
- Minimum spacing: the earliest next accept is the edge after the return handshake, since call_ready reasserts in IDLE.
- ret_data keeps its last returned value while in IDLE and MUL; it changes only on entry to RET or on reset.
- call_valid in RET or MUL is ignored (not accepted, not queued).
- Reset asserted mid-MUL or in RET:
  - the in-flight result is discarded and returns to reset values immediately;
  - no ret_valid is produced for that call after reset release.
- The call is not accepted if call_valid is high in the same cycle rst_n deasserts but before the first edge with rst_n high.

Test Plan:
- Add: call op=0, a=8, b=9 → ret_valid high 1 cycle after accept, ret_data=17; hold ret_ready=1 → IDLE next edge.
- Multiply: op=1, a=3, b=7, WIDTH=8 → ret_valid exactly 9 edges after accept, ret_data=21; busy high throughout.
- Extremes: op=1, a=255, b=255 → 65025 (16'hFE01); op=0, a=255, b=255 → 510 (carry in bit 8); op=1, a=0, b=200 → 0, still 9-edge latency.
- Back-pressure: ret_ready=0 for 5 cycles after ret_valid → ret_data stable, call_ready=0, a new call_valid is ignored; raise ret_ready → IDLE, then the new call is accepted on the following edge.
- Reset mid-operation: op=1, a=12, b=13; assert rst_n low after 4 MUL cycles → all outputs at reset values immediately; after release, no ret_valid appears; a fresh op=0 call with 1+1 returns 2.
- Back-to-back: ten random calls (mixed ops) with ret_ready tied high → each result matches a reference model and no call is lost or duplicated.

Source files
------------

// File: rtl/call_return_responder.sv
// call_return_responder
// Callee side of a call/return handshake. It accepts one call carrying two
// unsigned operands and an opcode. It then returns either the sum (computed in
// one step) or the product (computed by shift-add over WIDTH cycles). The
// result is held on the return channel until the initiator takes it.
//
// Ports:
//   clk        - single clock, rising-edge active
//   rst_n      - asynchronous active-low reset
//   call_valid - initiator presents a call
//   call_ready - responder can accept a call (high only in IDLE)
//   call_op    - 0 = add, 1 = multiply
//   call_a     - first operand, WIDTH bits, unsigned
//   call_b     - second operand, WIDTH bits, unsigned
//   ret_valid  - result available (high only in RET)
//   ret_ready  - initiator accepts the result
//   ret_data   - 2*WIDTH-bit result, held until the next result or reset
//   busy       - high in any state other than IDLE
module call_return_responder #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 call_valid,
  output logic                 call_ready,
  input  logic                 call_op,
  input  logic [WIDTH-1:0]     call_a,
  input  logic [WIDTH-1:0]     call_b,
  output logic                 ret_valid,
  input  logic                 ret_ready,
  output logic [2*WIDTH-1:0]   ret_data,
  output logic                 busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    RET  = 2'd2
  } state_t;

  state_t state, state_next;

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc_step;
  logic [2*WIDTH-1:0] sum;
  logic               last_step;

  // One shift-add step. The last step's value is written straight into
  // ret_data, so the product is ready on the same edge that leaves MUL.
  assign acc_step  = mplier[0] ? (acc + mcand) : acc;
  assign last_step = (cnt == CW'(WIDTH - 1));
  assign sum       = {{WIDTH{1'b0}}, call_a} + {{WIDTH{1'b0}}, call_b};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and handshake outputs. Every output depends only on
  // the state, so call_ready and ret_valid never depend combinationally on
  // the initiator's signals.
  always_comb begin
    state_next = state;
    call_ready = 1'b0;
    ret_valid  = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        call_ready = 1'b1;
        busy       = 1'b0;
        if (call_valid) begin
          state_next = call_op ? MUL : RET;
        end
      end
      MUL: begin
        if (last_step) begin
          state_next = RET;
        end
      end
      RET: begin
        ret_valid = 1'b1;
        if (ret_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath. Operands are captured only on the accept edge in IDLE.
  // ret_data is written only when entering RET, so it keeps the previous
  // result while the block is in IDLE and MUL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      cnt      <= '0;
      ret_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (call_valid) begin
            if (call_op) begin
              acc    <= '0;
              mcand  <= {{WIDTH{1'b0}}, call_a};
              mplier <= call_b;
              cnt    <= '0;
            end else begin
              ret_data <= sum;
            end
          end
        end
        MUL: begin
          acc    <= acc_step;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
          if (last_step) begin
            ret_data <= acc_step;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
